// File: rtl/axi_line_master_if.sv
// AXI4 read (AR+R) and write (AW+W+B) channel bundles used by the line master.
interface axi_read_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

interface axi_write_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_line_master.sv
// Whole-line AXI initiator: one read-line or write-line request becomes one fixed-length
// INCR burst; a single transaction is in flight at a time.
module axi_line_master #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  BEAT_WIDTH = 32,
    parameter int  BEATS      = 8,
    localparam int LINE_W     = BEATS * BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [LINE_W-1:0]     resp_rdata,
    axi_read_if.master            axi_read_if,
    axi_write_if.master           axi_write_if
);

    localparam int OFF = $clog2(LINE_W / 8);
    localparam int IW  = $clog2(BEATS);
    localparam int CW  = IW + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] BEAT_CNT  = CW'(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CW-1:0]         beat_reg, beat_next;
    logic                  err_reg, err_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic                  load_wline;
    logic [BEATS-1:0]      beat_we;

    logic [BEAT_WIDTH-1:0] line_reg  [BEATS];
    logic [BEAT_WIDTH-1:0] wline_reg [BEATS];

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[OFF-1:0]};

    // Control state: address, beat counter, error accumulator and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            beat_reg       <= '0;
            err_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            beat_reg       <= beat_next;
            err_reg        <= err_next;
            resp_valid_reg <= resp_valid_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_reg[gi] <= '0;
                end else if (beat_we[gi]) begin
                    line_reg[gi] <= axi_read_if.rdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wline_reg[gi] <= '0;
                end else if (load_wline) begin
                    wline_reg[gi] <= req_wdata[gi*BEAT_WIDTH +: BEAT_WIDTH];
                end
            end

            assign resp_rdata[gi*BEAT_WIDTH +: BEAT_WIDTH] = line_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        beat_next       = beat_reg;
        err_next        = err_reg;
        resp_valid_next = 1'b0;
        load_wline      = 1'b0;
        beat_we         = '0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next  = {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    beat_next  = '0;
                    err_next   = 1'b0;
                    load_wline = 1'b1;
                    state_next = req_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                if (axi_read_if.arready) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                if (axi_read_if.rvalid) begin
                    // Beats beyond the line length are discarded but flagged.
                    if (beat_reg < BEAT_CNT) begin
                        beat_we[beat_reg[IW-1:0]] = 1'b1;
                        beat_next = beat_reg + 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    if (axi_read_if.rresp != 2'b00) begin
                        err_next = 1'b1;
                    end
                    if (axi_read_if.rlast) begin
                        if (beat_reg != LAST_BEAT) begin
                            err_next = 1'b1;
                        end
                        state_next      = ST_IDLE;
                        resp_valid_next = 1'b1;
                    end
                end
            end
            ST_AW: begin
                if (axi_write_if.awready) begin
                    state_next = ST_W;
                end
            end
            ST_W: begin
                if (axi_write_if.wready) begin
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = ST_B;
                    end
                end
            end
            ST_B: begin
                if (axi_write_if.bvalid) begin
                    if (axi_write_if.bresp != 2'b00) begin
                        err_next = 1'b1;
                    end
                    state_next      = ST_IDLE;
                    resp_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_err   = err_reg;

    // Address and length stay on the bus for the whole transaction; some slaves sample len late.
    assign axi_read_if.araddr  = addr_reg;
    assign axi_read_if.arlen   = 8'(BEATS - 1);
    assign axi_read_if.arsize  = 3'($clog2(BEAT_WIDTH / 8));
    assign axi_read_if.arburst = 2'b01;
    assign axi_read_if.arvalid = (state_reg == ST_AR);
    assign axi_read_if.rready  = (state_reg == ST_R);

    assign axi_write_if.awaddr  = addr_reg;
    assign axi_write_if.awlen   = 8'(BEATS - 1);
    assign axi_write_if.awsize  = 3'($clog2(BEAT_WIDTH / 8));
    assign axi_write_if.awburst = 2'b01;
    assign axi_write_if.awvalid = (state_reg == ST_AW);
    assign axi_write_if.wvalid  = (state_reg == ST_W);
    assign axi_write_if.wdata   = wline_reg[beat_reg[IW-1:0]];
    assign axi_write_if.wstrb   = '1;
    assign axi_write_if.wlast   = (state_reg == ST_W) && (beat_reg == LAST_BEAT);
    assign axi_write_if.bready  = (state_reg == ST_B);

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: a scripted AXI slave backed by a word array.
module tb_axi_line_master;

    localparam int AW = 32;
    localparam int BW = 32;
    localparam int NB = 8;
    localparam int LW = NB * BW;

    localparam logic [255:0] LINE_A = 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [255:0] LINE_W = 256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_A5A50000;
    localparam logic [255:0] LINE_X = 256'h12340007_12340006_12340005_12340004_12340003_12340002_12340001_12340000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_err;
    logic [LW-1:0] resp_rdata;

    axi_read_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(BW)) rd_bus ();
    axi_write_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(BW)) wr_bus ();

    axi_line_master #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .axi_read_if  (rd_bus),
        .axi_write_if (wr_bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:4095];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [255:0] line);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = line;
        check("req_ready_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 1'b0);
    endtask

    task automatic serve_ar(input logic [31:0] exp_addr, input int wait_cycles);
        int t = 0;
        while (rd_bus.arvalid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("arvalid", rd_bus.arvalid, 1'b1);
        check("araddr", rd_bus.araddr, exp_addr);
        check("arlen", rd_bus.arlen, 8'd7);
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            check("arvalid_hold", rd_bus.arvalid, 1'b1);
            check("araddr_hold", rd_bus.araddr, exp_addr);
        end
        rd_bus.arready = 1'b1;
        tick();
        rd_bus.arready = 1'b0;
        check("arvalid_drop", rd_bus.arvalid, 1'b0);
    endtask

    task automatic serve_r(input logic [31:0] base, input logic gapped, input int err_beat, input int last_beat);
        logic [11:0] idx = base[13:2];
        for (int b = 0; b <= last_beat; b++) begin
            if (gapped && b > 0) begin
                rd_bus.rvalid = 1'b0;
                tick();
            end
            check("rready", rd_bus.rready, 1'b1);
            check("resp_valid_busy", resp_valid, 1'b0);
            rd_bus.rvalid = 1'b1;
            rd_bus.rdata  = mem[idx + 12'(b)];
            rd_bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rd_bus.rlast  = (b == last_beat);
            tick();
        end
        rd_bus.rvalid = 1'b0;
        rd_bus.rlast  = 1'b0;
        rd_bus.rresp  = 2'b00;
    endtask

    task automatic serve_write(input logic [31:0] exp_addr, input int stall_beat, input logic bad, input logic [255:0] line);
        logic [11:0] idx = exp_addr[13:2];
        int t = 0;
        while (wr_bus.awvalid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("awvalid", wr_bus.awvalid, 1'b1);
        check("awaddr", wr_bus.awaddr, exp_addr);
        check("awlen", wr_bus.awlen, 8'd7);
        wr_bus.awready = 1'b1;
        tick();
        wr_bus.awready = 1'b0;
        check("awvalid_drop", wr_bus.awvalid, 1'b0);
        for (int b = 0; b < NB; b++) begin
            check("wvalid", wr_bus.wvalid, 1'b1);
            check("wdata", wr_bus.wdata, line[b*32 +: 32]);
            check("wlast", wr_bus.wlast, (b == NB - 1));
            check("wstrb", wr_bus.wstrb, 4'hF);
            if (b == stall_beat) begin
                wr_bus.wready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check("wvalid_hold", wr_bus.wvalid, 1'b1);
                    check("wdata_hold", wr_bus.wdata, line[b*32 +: 32]);
                    check("wlast_hold", wr_bus.wlast, 1'b0);
                end
            end
            wr_bus.wready = 1'b1;
            mem[idx + 12'(b)] = wr_bus.wdata;
            tick();
        end
        wr_bus.wready = 1'b0;
        check("wvalid_done", wr_bus.wvalid, 1'b0);
        check("bready", wr_bus.bready, 1'b1);
        wr_bus.bvalid = 1'b1;
        wr_bus.bresp  = bad ? 2'b10 : 2'b00;
        tick();
        wr_bus.bvalid = 1'b0;
        wr_bus.bresp  = 2'b00;
    endtask

    task automatic expect_resp(input logic exp_err, input logic [255:0] exp_line, input logic chk_data);
        check("resp_valid", resp_valid, 1'b1);
        check("resp_err", resp_err, exp_err);
        check("req_ready_done", req_ready, 1'b1);
        if (chk_data) begin
            check("resp_rdata", resp_rdata, exp_line);
        end
        tick();
        check("resp_valid_pulse", resp_valid, 1'b0);
    endtask

    initial begin
        logic [255:0] line_a;
        line_a = LINE_A;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int k = 0; k < NB; k++) mem[12'h400 + k] = line_a[k*32 +: 32];

        rd_bus.arready = 1'b0;
        rd_bus.rvalid  = 1'b0;
        rd_bus.rdata   = '0;
        rd_bus.rresp   = 2'b00;
        rd_bus.rlast   = 1'b0;
        wr_bus.awready = 1'b0;
        wr_bus.wready  = 1'b0;
        wr_bus.bvalid  = 1'b0;
        wr_bus.bresp   = 2'b00;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, '0);
        check("rst_valids", {rd_bus.arvalid, rd_bus.rready, wr_bus.awvalid, wr_bus.wvalid, wr_bus.bready}, '0);
        rst_n = 1'b1;
        tick();

        // Plain read, unaligned request address.
        send_req(1'b0, 32'h0000_1004, '0);
        check("ar_latency", rd_bus.arvalid, 1'b1);
        serve_ar(32'h0000_1000, 0);
        serve_r(32'h0000_1000, 1'b0, -1, 7);
        check("rdata_lo", resp_rdata[31:0], 32'h03020100);
        check("rdata_hi", resp_rdata[255:224], 32'h1F1E1D1C);
        expect_resp(1'b0, LINE_A, 1'b1);

        // Plain write then read-back.
        send_req(1'b1, 32'h0000_2000, LINE_W);
        check("aw_latency", wr_bus.awvalid, 1'b1);
        serve_write(32'h0000_2000, -1, 1'b0, LINE_W);
        expect_resp(1'b0, '0, 1'b0);
        send_req(1'b0, 32'h0000_2000, '0);
        serve_ar(32'h0000_2000, 0);
        serve_r(32'h0000_2000, 1'b0, -1, 7);
        expect_resp(1'b0, LINE_W, 1'b1);

        // Read with arready delay and gapped rvalid.
        send_req(1'b0, 32'h0000_201C, '0);
        serve_ar(32'h0000_2000, 3);
        serve_r(32'h0000_2000, 1'b1, -1, 7);
        expect_resp(1'b0, LINE_W, 1'b1);

        // Write with mid-burst wready stall and SLVERR bresp, then clean read-back.
        send_req(1'b1, 32'h0000_2024, LINE_X);
        serve_write(32'h0000_2020, 3, 1'b1, LINE_X);
        expect_resp(1'b1, '0, 1'b0);
        send_req(1'b0, 32'h0000_2020, '0);
        serve_ar(32'h0000_2020, 0);
        serve_r(32'h0000_2020, 1'b0, -1, 7);
        expect_resp(1'b0, LINE_X, 1'b1);

        // SLVERR on beat 4: full line still consumed.
        send_req(1'b0, 32'h0000_1000, '0);
        serve_ar(32'h0000_1000, 0);
        serve_r(32'h0000_1000, 1'b0, 4, 7);
        expect_resp(1'b1, LINE_A, 1'b1);

        // Early rlast on beat 5.
        send_req(1'b0, 32'h0000_2000, '0);
        serve_ar(32'h0000_2000, 0);
        serve_r(32'h0000_2000, 1'b0, -1, 5);
        expect_resp(1'b1, '0, 1'b0);

        // Two extra beats past the line: dropped, flagged.
        send_req(1'b0, 32'h0000_1000, '0);
        serve_ar(32'h0000_1000, 0);
        serve_r(32'h0000_1000, 1'b0, -1, 9);
        expect_resp(1'b1, LINE_A, 1'b1);

        // Back-to-back: next request waits through the burst, accepted in the resp_valid cycle.
        send_req(1'b0, 32'h0000_2000, '0);
        serve_ar(32'h0000_2000, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_1010;
        check("b2b_not_ready", req_ready, 1'b0);
        serve_r(32'h0000_2000, 1'b0, -1, 7);
        check("b2b_resp_valid", resp_valid, 1'b1);
        check("b2b_resp_rdata", resp_rdata, LINE_W);
        check("b2b_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("b2b_pulse", resp_valid, 1'b0);
        check("b2b_arvalid", rd_bus.arvalid, 1'b1);
        serve_ar(32'h0000_1000, 0);
        serve_r(32'h0000_1000, 1'b0, -1, 7);
        expect_resp(1'b0, LINE_A, 1'b1);

        // Reset after beat 3 abandons the burst.
        send_req(1'b0, 32'h0000_2020, '0);
        serve_ar(32'h0000_2020, 0);
        for (int b = 0; b < 4; b++) begin
            rd_bus.rvalid = 1'b1;
            rd_bus.rdata  = mem[12'h808 + b];
            rd_bus.rlast  = 1'b0;
            tick();
        end
        rd_bus.rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {rd_bus.arvalid, rd_bus.rready, wr_bus.awvalid, wr_bus.wvalid, wr_bus.bready}, '0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_rdata", resp_rdata, '0);
        tick();
        check("post_rst_resp_valid", resp_valid, 1'b0);
        send_req(1'b0, 32'h0000_2020, '0);
        serve_ar(32'h0000_2020, 0);
        serve_r(32'h0000_2020, 1'b0, -1, 7);
        expect_resp(1'b0, LINE_X, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
